// File: rtl/alu_sequencer_pkg.sv
// Shared types, encodings and decimal-adjust helpers for the 6502 ALU sequencer.
// The external ALU registers its result; ALU_SR shifts a left by b[2:0].
package alu_sequencer_pkg;

  localparam int unsigned REG_WIDTH = 8;
  localparam int unsigned OPP_WIDTH = 4;
  localparam int unsigned OP_WIDTH  = 4;

  typedef logic [REG_WIDTH-1:0] word_t;

  typedef enum logic [OPP_WIDTH-1:0] {
    ALU_NOP = OPP_WIDTH'(0),
    ALU_SUM = OPP_WIDTH'(1),
    ALU_AND = OPP_WIDTH'(2),
    ALU_OR  = OPP_WIDTH'(3),
    ALU_XOR = OPP_WIDTH'(4),
    ALU_SR  = OPP_WIDTH'(5)
  } alu_func_e;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADC = OP_WIDTH'(0),
    OP_SBC = OP_WIDTH'(1),
    OP_AND = OP_WIDTH'(2),
    OP_ORA = OP_WIDTH'(3),
    OP_EOR = OP_WIDTH'(4),
    OP_CMP = OP_WIDTH'(5),
    OP_ASL = OP_WIDTH'(6),
    OP_INC = OP_WIDTH'(7),
    OP_DEC = OP_WIDTH'(8)
  } seq_op_e;

  localparam int unsigned P_N = 7;
  localparam int unsigned P_V = 6;
  localparam int unsigned P_B = 4;
  localparam int unsigned P_D = 3;
  localparam int unsigned P_I = 2;
  localparam int unsigned P_Z = 1;
  localparam int unsigned P_C = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_DADJ_ISSUE,
    S_DADJ_CAPTURE,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    seq_op_e op;
    word_t   a;
    word_t   b;
    word_t   p;
  } seq_req_t;

  // Low-nibble decimal carry for ADC.
  function automatic logic adc_lo(input word_t a, input word_t b, input logic cin);
    return (5'(a[3:0]) + 5'(b[3:0]) + 5'(cin)) > 5'd9;
  endfunction

  // High-digit decimal carry for ADC; also the final C in decimal mode.
  function automatic logic adc_hi(input word_t r_bin, input logic c8, input logic lo);
    word_t t;
    t = r_bin + (lo ? 8'h06 : 8'h00);
    return c8 | (r_bin > 8'h99) | (t[7:4] > 4'd9);
  endfunction

  // Low-nibble decimal borrow for SBC.
  function automatic logic sbc_lo(input word_t a, input word_t b, input logic cin);
    return 5'(a[3:0]) < (5'(b[3:0]) + 5'(!cin));
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/V/Z/C derivation for the ALU sequencer.
module alu_flag_gen
  import alu_sequencer_pkg::*;
(
  input  seq_op_e              op,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  input  logic [REG_WIDTH-1:0] r,
  input  logic [REG_WIDTH-1:0] r_bin,
  input  logic [REG_WIDTH-1:0] status_in,
  input  logic                 c8,
  input  logic                 dec_mode,
  output logic [REG_WIDTH-1:0] status_c
);

  always_comb begin
    status_c      = status_in;
    status_c[P_N] = r[REG_WIDTH-1];
    status_c[P_Z] = (r == '0);
    case (op)
      OP_ADC: begin
        status_c[P_C] = dec_mode ? adc_hi(r_bin, c8, adc_lo(a, b, status_in[P_C])) : c8;
        status_c[P_V] = (a[7] == b[7]) && (r_bin[7] != a[7]);
      end
      // Subtraction overflow: operand B enters the adder inverted.
      OP_SBC: begin
        status_c[P_C] = c8;
        status_c[P_V] = (a[7] != b[7]) && (r_bin[7] != a[7]);
      end
      OP_CMP:  status_c[P_C] = c8;
      OP_ASL:  status_c[P_C] = a[7];
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller sequencing the 6502 ALU for arithmetic, logic and compare ops,
// with an optional second pass for decimal adjust.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic                 phi1,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OP_WIDTH-1:0]  op,
  input  logic [REG_WIDTH-1:0] opa,
  input  logic [REG_WIDTH-1:0] opb,
  input  logic [REG_WIDTH-1:0] status_in,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] result,
  output logic [REG_WIDTH-1:0] status_out,
  output logic                 wr_result,
  output logic [OPP_WIDTH-1:0] alu_func,
  output logic [REG_WIDTH-1:0] alu_a,
  output logic [REG_WIDTH-1:0] alu_b,
  output logic                 alu_carry_in,
  input  logic [REG_WIDTH-1:0] alu_dout,
  input  logic                 alu_carry_out
);

  seq_state_e           state, state_nxt;
  seq_req_t             req, req_nxt;
  word_t                r_bin, r_bin_nxt;
  logic                 c8, c8_nxt;
  logic                 busy_nxt, done_nxt, wr_result_nxt;
  word_t                result_nxt, status_nxt;
  logic [OPP_WIDTH-1:0] func_nxt;
  word_t                a_nxt, b_nxt;
  logic                 cin_nxt;

  seq_op_e              op_in;
  logic [OPP_WIDTH-1:0] iss_func;
  word_t                iss_b;
  logic                 iss_cin;
  logic                 dec_mode;
  logic                 dadj_lo, dadj_hi;
  word_t                dadj_b;
  word_t                fg_rbin;
  logic                 fg_c8;
  word_t                flags_c;

  assign op_in    = seq_op_e'(op);
  assign dec_mode = req.p[P_D] && ((req.op == OP_ADC) || (req.op == OP_SBC));

  // First-pass ALU drive, decoded from the request being accepted.
  always_comb begin
    iss_func = ALU_SUM;
    iss_b    = opb;
    iss_cin  = status_in[P_C];
    case (op_in)
      OP_ADC: ;
      OP_SBC: iss_b = ~opb;
      OP_CMP: begin iss_b = ~opb;  iss_cin = 1'b1; end
      OP_AND: begin iss_func = ALU_AND; iss_cin = 1'b0; end
      OP_ORA: begin iss_func = ALU_OR;  iss_cin = 1'b0; end
      OP_EOR: begin iss_func = ALU_XOR; iss_cin = 1'b0; end
      OP_ASL: begin iss_func = ALU_SR;  iss_b = 8'h01; iss_cin = 1'b0; end
      OP_INC: begin iss_b = 8'h00; iss_cin = 1'b1; end
      OP_DEC: begin iss_b = 8'hFF; iss_cin = 1'b0; end
      default: begin iss_func = ALU_NOP; iss_b = '0; iss_cin = 1'b0; end
    endcase
  end

  // Decimal correction term, computed while the binary result is on alu_dout.
  always_comb begin
    dadj_lo = 1'b0;
    dadj_hi = 1'b0;
    dadj_b  = '0;
    if (req.op == OP_SBC) begin
      dadj_lo = sbc_lo(req.a, req.b, req.p[P_C]);
      dadj_hi = !alu_carry_out;
      dadj_b  = (dadj_lo && dadj_hi) ? 8'h9A : dadj_hi ? 8'hA0 : dadj_lo ? 8'hFA : 8'h00;
    end else begin
      dadj_lo = adc_lo(req.a, req.b, req.p[P_C]);
      dadj_hi = adc_hi(alu_dout, alu_carry_out, dadj_lo);
      dadj_b  = {dadj_hi ? 4'h6 : 4'h0, dadj_lo ? 4'h6 : 4'h0};
    end
  end

  assign fg_rbin = (state == S_CAPTURE) ? alu_dout      : r_bin;
  assign fg_c8   = (state == S_CAPTURE) ? alu_carry_out : c8;

  alu_flag_gen u_flag_gen (
    .op        (req.op),
    .a         (req.a),
    .b         (req.b),
    .r         (alu_dout),
    .r_bin     (fg_rbin),
    .status_in (req.p),
    .c8        (fg_c8),
    .dec_mode  (dec_mode),
    .status_c  (flags_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    req_nxt       = req;
    r_bin_nxt     = r_bin;
    c8_nxt        = c8;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    wr_result_nxt = wr_result;
    result_nxt    = result;
    status_nxt    = status_out;
    func_nxt      = ALU_NOP;
    a_nxt         = '0;
    b_nxt         = '0;
    cin_nxt       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ISSUE;
          req_nxt   = '{op: op_in, a: opa, b: opb, p: status_in};
          busy_nxt  = 1'b1;
          func_nxt  = iss_func;
          a_nxt     = opa;
          b_nxt     = iss_b;
          cin_nxt   = iss_cin;
        end
      end
      S_ISSUE: state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        r_bin_nxt = alu_dout;
        c8_nxt    = alu_carry_out;
        if (dec_mode) begin
          state_nxt = S_DADJ_ISSUE;
          func_nxt  = ALU_SUM;
          a_nxt     = alu_dout;
          b_nxt     = dadj_b;
        end else begin
          state_nxt     = S_DONE;
          busy_nxt      = 1'b0;
          done_nxt      = 1'b1;
          wr_result_nxt = (req.op != OP_CMP);
          result_nxt    = alu_dout;
          status_nxt    = flags_c;
        end
      end
      S_DADJ_ISSUE: state_nxt = S_DADJ_CAPTURE;
      S_DADJ_CAPTURE: begin
        state_nxt     = S_DONE;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b1;
        wr_result_nxt = (req.op != OP_CMP);
        result_nxt    = alu_dout;
        status_nxt    = flags_c;
      end
      S_DONE: begin
        state_nxt     = S_IDLE;
        wr_result_nxt = 1'b0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      req          <= '0;
      r_bin        <= '0;
      c8           <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_result    <= 1'b0;
      result       <= '0;
      status_out   <= '0;
      alu_func     <= ALU_NOP;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_carry_in <= 1'b0;
    end else begin
      state        <= state_nxt;
      req          <= req_nxt;
      r_bin        <= r_bin_nxt;
      c8           <= c8_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      wr_result    <= wr_result_nxt;
      result       <= result_nxt;
      status_out   <= status_nxt;
      alu_func     <= func_nxt;
      alu_a        <= a_nxt;
      alu_b        <= b_nxt;
      alu_carry_in <= cin_nxt;
    end
  end

endmodule
